// File: rtl/exec_stage_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU operation
// classes, R-type funct codes and the multiply/divide FSM state encoding.
// Imported by exec_stage and muldiv_iter.
package exec_stage_pkg;

  localparam int XLEN = 32;

  // aluop classes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_LUI = 3'b111;

  // R-type funct codes
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // Multiply/divide FSM
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_t;

  // MULT/MULTU/DIV/DIVU share the 0110xx prefix; the low two bits then
  // encode {is_div, is_unsigned}, which is the muldiv_iter op encoding.
  function automatic logic is_md_funct(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Ports: start/op/a/b accept an operation when idle; busy is high for exactly
// MD_CYCLES cycles afterwards; hi/lo hold the last completed result.
// op[1]=divide, op[0]=unsigned. Shift-add multiply and restoring divide run on
// operand magnitudes; signs are applied on the final iteration.
module muldiv_iter #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  import exec_stage_pkg::*;

  localparam int CNT_W = $clog2(MD_CYCLES) + 1;

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    ma_q, ma_d;      // multiplicand / dividend magnitude
  logic [XLEN-1:0]    mb_q, mb_d;      // multiplier / divisor magnitude
  logic               neg_q, neg_d;    // product / quotient is negative
  logic               rneg_q, rneg_d;  // remainder is negative (dividend sign)
  logic               dz_q, dz_d;      // divide by zero
  logic [2*XLEN-1:0]  acc_q, acc_d;    // mul: {partial, multiplier}; div: {rem, quo}
  logic [XLEN-1:0]    hi_q, hi_d;
  logic [XLEN-1:0]    lo_q, lo_d;

  logic               a_neg, b_neg;
  logic [XLEN-1:0]    a_mag, b_mag;
  logic [XLEN:0]      mul_sum;
  logic [2*XLEN-1:0]  mul_nxt;
  logic [2*XLEN-1:0]  mul_fix;
  logic [XLEN:0]      div_shift;
  logic [XLEN:0]      div_diff;
  logic               div_ok;
  logic [2*XLEN-1:0]  div_nxt;
  logic               last;

  assign a_neg = !op[0] && a[XLEN-1];
  assign b_neg = !op[0] && b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One shift-add step: add multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? ma_q : {XLEN{1'b0}})};
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_fix = neg_q ? -mul_nxt : mul_nxt;

  // One restoring step: shift next dividend bit into the remainder and keep
  // the subtraction only when it does not go negative.
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mb_q};
  assign div_ok    = !div_diff[XLEN];
  assign div_nxt   = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ok};

  assign last = (cnt_q == CNT_W'(MD_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ma_d    = a_mag;
          mb_d    = b_mag;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (b == '0);
          cnt_d   = '0;
          acc_d   = op[1] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          state_d = op[1] ? DIV : MUL;
        end
      end
      MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          hi_d    = mul_fix[2*XLEN-1:XLEN];
          lo_d    = mul_fix[XLEN-1:0];
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          // Divide by zero: the magnitude loop already leaves |a| in the
          // remainder, so only the quotient needs forcing to all ones.
          hi_d    = rneg_q ? -div_nxt[2*XLEN-1:XLEN] : div_nxt[2*XLEN-1:XLEN];
          lo_d    = dz_q   ? {XLEN{1'b1}}
                  : (neg_q ? -div_nxt[XLEN-1:0] : div_nxt[XLEN-1:0]);
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand-B mux, combinational ALU, EX/MEM pipeline register,
// and the iterative multiply/divide unit that owns HI/LO.
// Ports: decode/execute operands and control in; stall back to upstream;
// registered out_valid/alu_out/st_data/out_AW/out_* control to EX/MEM.
// Latency 1 for ALU ops; mul/div stalls upstream for MD_CYCLES cycles.
module exec_stage #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] dr1,
  input  logic [XLEN-1:0] dr2,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      AW,
  input  logic [2:0]      aluop,
  input  logic [5:0]      sel,
  input  logic            regwrite,
  input  logic            memtoreg,
  input  logic            memwrite,
  input  logic            alusrc,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] st_data,
  output logic [4:0]      out_AW,
  output logic            out_regwrite,
  output logic            out_memtoreg,
  output logic            out_memwrite
);
  import exec_stage_pkg::*;

  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] alu_res;
  logic            is_md;
  logic            md_busy;
  logic            md_start;
  logic            take;
  logic [XLEN-1:0] md_hi, md_lo;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] st_q, st_d;
  logic [4:0]      aw_q, aw_d;
  logic            rw_q, rw_d;
  logic            mtr_q, mtr_d;
  logic            mw_q, mw_d;

  assign opb = alusrc ? imm : dr2;

  always_comb begin
    alu_res = '0;
    is_md   = 1'b0;
    case (aluop)
      ALU_ADD: alu_res = dr1 + opb;
      ALU_SUB: alu_res = dr1 - opb;
      ALU_AND: alu_res = dr1 & opb;
      ALU_OR:  alu_res = dr1 | opb;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(dr1) < $signed(opb))};
      ALU_XOR: alu_res = dr1 ^ opb;
      ALU_LUI: alu_res = opb << 16;
      ALU_R: begin
        is_md = is_md_funct(sel);
        case (sel)
          F_ADD:  alu_res = dr1 + opb;
          F_SUB:  alu_res = dr1 - opb;
          F_AND:  alu_res = dr1 & opb;
          F_OR:   alu_res = dr1 | opb;
          F_XOR:  alu_res = dr1 ^ opb;
          F_NOR:  alu_res = ~(dr1 | opb);
          F_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(dr1) < $signed(opb))};
          F_SLTU: alu_res = {{(XLEN-1){1'b0}}, (dr1 < opb)};
          F_MFHI: alu_res = md_hi;
          F_MFLO: alu_res = md_lo;
          default: alu_res = '0;  // unknown funct and mul/div write zero
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // Inputs are only honoured while the mul/div unit is idle.
  assign take     = in_valid && !md_busy && !is_md;
  assign md_start = in_valid && !md_busy && is_md;

  muldiv_iter #(
    .XLEN      (XLEN),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (sel[1:0]),
    .a     (dr1),
    .b     (opb),
    .busy  (md_busy),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  // Anything other than an accepted single-cycle op becomes a bubble.
  always_comb begin
    valid_d = take;
    alu_d   = take ? alu_res  : '0;
    st_d    = take ? dr2      : '0;
    aw_d    = take ? AW       : '0;
    rw_d    = take && regwrite;
    mtr_d   = take && memtoreg;
    mw_d    = take && memwrite;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      st_q    <= '0;
      aw_q    <= '0;
      rw_q    <= 1'b0;
      mtr_q   <= 1'b0;
      mw_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      st_q    <= st_d;
      aw_q    <= aw_d;
      rw_q    <= rw_d;
      mtr_q   <= mtr_d;
      mw_q    <= mw_d;
    end
  end

  assign stall        = md_busy;
  assign out_valid    = valid_q;
  assign alu_out      = alu_q;
  assign st_data      = st_q;
  assign out_AW       = aw_q;
  assign out_regwrite = rw_q;
  assign out_memtoreg = mtr_q;
  assign out_memwrite = mw_q;

endmodule

// File: tb/tb_exec_stage.sv
module tb_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] dr1, dr2, imm;
  logic [4:0]  AW;
  logic [2:0]  aluop;
  logic [5:0]  sel;
  logic        regwrite, memtoreg, memwrite, alusrc;
  logic        stall, out_valid;
  logic [31:0] alu_out, st_data;
  logic [4:0]  out_AW;
  logic        out_regwrite, out_memtoreg, out_memwrite;

  int n_chk;
  int n_fail;

  exec_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .dr1          (dr1),
    .dr2          (dr2),
    .imm          (imm),
    .AW           (AW),
    .aluop        (aluop),
    .sel          (sel),
    .regwrite     (regwrite),
    .memtoreg     (memtoreg),
    .memwrite     (memwrite),
    .alusrc       (alusrc),
    .stall        (stall),
    .out_valid    (out_valid),
    .alu_out      (alu_out),
    .st_data      (st_data),
    .out_AW       (out_AW),
    .out_regwrite (out_regwrite),
    .out_memtoreg (out_memtoreg),
    .out_memwrite (out_memwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [4:0] aw, input logic [2:0] op,
                        input logic [5:0] f, input logic rw, input logic mtr,
                        input logic mw, input logic asrc);
    in_valid = v; dr1 = a; dr2 = b; imm = im; AW = aw; aluop = op; sel = f;
    regwrite = rw; memtoreg = mtr; memwrite = mw; alusrc = asrc;
  endtask

  // R-type op with regwrite set
  task automatic set_r(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    set_in(1'b1, a, b, 32'h0, 5'd3, 3'b010, f, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Wait out a mul/div; n returns the number of cycles stall was seen high.
  task automatic wait_idle(output int n);
    n = 0;
    while (stall && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    set_in(1'b0, 0, 0, 0, 0, 3'b000, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_chk++; if ({alu_out, st_data} !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", alu_out, st_data); end
    n_chk++; if ({out_AW, out_regwrite, out_memtoreg, out_memwrite} !== 8'h0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h %b%b%b expected all 0", out_AW, out_regwrite, out_memtoreg, out_memwrite);
    end
    step(); step();
    rst_n = 1'b1;
    set_r(0, 0, 6'b010000);  // MFHI
    step();
    n_chk++; if (alu_out !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", alu_out); end
  endtask

  task automatic test_alu();
    set_r(32'd5, 32'd7, 6'b100010);  // SUB
    step();
    n_chk++; if (alu_out !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sub: got %h expected fffffffe", alu_out); end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sub_valid: got %b expected 1", out_valid); end
    set_r(32'hFFFFFFFF, 32'd1, 6'b101010);  // SLT: -1 < 1
    step();
    n_chk++; if (alu_out !== 32'd1) begin n_fail++; $display("FAIL slt: got %h expected 00000001", alu_out); end
    set_r(32'hFFFFFFFF, 32'd1, 6'b101011);  // SLTU: ffffffff < 1 is false
    step();
    n_chk++; if (alu_out !== 32'd0) begin n_fail++; $display("FAIL sltu: got %h expected 00000000", alu_out); end
    set_in(1'b1, 32'd1, 32'd99, 32'hFFFFFFFF, 5'd4, 3'b000, 6'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    n_chk++; if (alu_out !== 32'd0) begin n_fail++; $display("FAIL addi: got %h expected 00000000", alu_out); end
    set_r(32'h0000F0F0, 32'h00000F0F, 6'b100111);  // NOR
    step();
    n_chk++; if (alu_out !== 32'hFFFF0000) begin n_fail++; $display("FAIL nor: got %h expected ffff0000", alu_out); end
    set_in(1'b1, 32'd5, 32'd6, 32'd0, 5'd9, 3'b010, 6'b111111, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    n_chk++; if ({alu_out, out_valid, out_regwrite, out_memtoreg} !== {32'h0, 3'b111}) begin
      n_fail++; $display("FAIL bad_funct: got %h %b%b%b expected 00000000 111", alu_out, out_valid, out_regwrite, out_memtoreg);
    end
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, 32'h0000F0F0, 32'h0000FF00, 0, 5'd1, 3'b011, 6'h0, 1'b1, 1'b0, 1'b0, 1'b0);  // AND
    step();
    n_chk++; if ({out_valid, alu_out} !== {1'b1, 32'h0000F000}) begin n_fail++; $display("FAIL b2b_and: got %b %h expected 1 0000f000", out_valid, alu_out); end
    set_in(1'b1, 32'h0000F0F0, 32'h00000F0F, 0, 5'd2, 3'b100, 6'h0, 1'b1, 1'b0, 1'b0, 1'b0);  // OR
    step();
    n_chk++; if ({out_valid, alu_out} !== {1'b1, 32'h0000FFFF}) begin n_fail++; $display("FAIL b2b_or: got %b %h expected 1 0000ffff", out_valid, alu_out); end
    set_in(1'b1, 32'h000000FF, 32'h0000000F, 0, 5'd3, 3'b110, 6'h0, 1'b1, 1'b0, 1'b0, 1'b0);  // XOR
    step();
    n_chk++; if ({out_valid, alu_out} !== {1'b1, 32'h000000F0}) begin n_fail++; $display("FAIL b2b_xor: got %b %h expected 1 000000f0", out_valid, alu_out); end
    set_in(1'b1, 32'd10, 32'd3, 0, 5'd4, 3'b001, 6'h0, 1'b1, 1'b0, 1'b0, 1'b0);  // SUB
    step();
    n_chk++; if ({out_valid, alu_out} !== {1'b1, 32'd7}) begin n_fail++; $display("FAIL b2b_sub: got %b %h expected 1 00000007", out_valid, alu_out); end
    set_in(1'b1, 32'hFFFFFFFE, 32'd0, 32'd1, 5'd5, 3'b101, 6'h0, 1'b1, 1'b0, 1'b0, 1'b1);  // SLTI -2 < 1
    step();
    n_chk++; if ({out_valid, alu_out} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL b2b_slti: got %b %h expected 1 00000001", out_valid, alu_out); end
  endtask

  task automatic test_mult();
    int n;
    set_r(32'hFFFFFFFE, 32'd3, 6'b011000);  // MULT
    step();
    set_in(1'b0, 0, 0, 0, 0, 3'b000, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({stall, out_valid, out_regwrite} !== 3'b100) begin n_fail++; $display("FAIL mult_accept: stall/valid/rw got %b%b%b expected 100", stall, out_valid, out_regwrite); end
    wait_idle(n);
    n_chk++; if (n !== 32) begin n_fail++; $display("FAIL mult_stall_len: got %0d cycles expected 32", n); end
    set_r(0, 0, 6'b010000);  // MFHI
    step();
    n_chk++; if (alu_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", alu_out); end
    set_r(0, 0, 6'b010010);  // MFLO
    step();
    n_chk++; if (alu_out !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffffa", alu_out); end
    set_r(32'hFFFFFFFE, 32'd3, 6'b011001);  // MULTU
    step();
    set_in(1'b0, 0, 0, 0, 0, 3'b000, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle(n);
    set_r(0, 0, 6'b010000);
    step();
    n_chk++; if (alu_out !== 32'h2) begin n_fail++; $display("FAIL multu_hi: got %h expected 00000002", alu_out); end
    set_r(0, 0, 6'b010010);
    step();
    n_chk++; if (alu_out !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL multu_lo: got %h expected fffffffa", alu_out); end
  endtask

  task automatic test_div();
    int n;
    set_r(32'hFFFFFFF9, 32'd2, 6'b011010);  // DIV -7/2
    step();
    set_in(1'b0, 0, 0, 0, 0, 3'b000, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle(n);
    set_r(0, 0, 6'b010010);
    step();
    n_chk++; if (alu_out !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", alu_out); end
    set_r(0, 0, 6'b010000);
    step();
    n_chk++; if (alu_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", alu_out); end
    set_r(32'd7, 32'd0, 6'b011011);  // DIVU 7/0
    step();
    set_in(1'b0, 0, 0, 0, 0, 3'b000, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle(n);
    n_chk++; if (n !== 32) begin n_fail++; $display("FAIL divz_stall_len: got %0d cycles expected 32", n); end
    set_r(0, 0, 6'b010010);
    step();
    n_chk++; if (alu_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divz_lo: got %h expected ffffffff", alu_out); end
    set_r(0, 0, 6'b010000);
    step();
    n_chk++; if (alu_out !== 32'd7) begin n_fail++; $display("FAIL divz_hi: got %h expected 00000007", alu_out); end
    set_r(32'h80000000, 32'hFFFFFFFF, 6'b011010);  // signed overflow case
    step();
    set_in(1'b0, 0, 0, 0, 0, 3'b000, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle(n);
    set_r(0, 0, 6'b010010);
    step();
    n_chk++; if (alu_out !== 32'h80000000) begin n_fail++; $display("FAIL divovf_lo: got %h expected 80000000", alu_out); end
    set_r(0, 0, 6'b010000);
    step();
    n_chk++; if (alu_out !== 32'h0) begin n_fail++; $display("FAIL divovf_hi: got %h expected 00000000", alu_out); end
  endtask

  task automatic test_stall_inputs();
    int n;
    set_r(32'd100, 32'd7, 6'b011011);  // DIVU 100/7 -> q=14, r=2
    step();
    n = 0;
    while (stall && n < 100) begin
      set_in(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 5'($urandom),
             3'b010, (n % 2 == 0) ? 6'b011000 : 6'b100000, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      n++;
      n_chk++; if ({out_valid, out_regwrite, out_memtoreg, out_memwrite} !== 4'b0000) begin
        n_fail++; $display("FAIL stall_bubble: cycle %0d got %b%b%b%b expected 0000", n, out_valid, out_regwrite, out_memtoreg, out_memwrite);
      end
    end
    n_chk++; if (n !== 32) begin n_fail++; $display("FAIL stall_len_random: got %0d cycles expected 32", n); end
    set_r(0, 0, 6'b010010);
    step();
    n_chk++; if (alu_out !== 32'd14) begin n_fail++; $display("FAIL stall_lo: got %h expected 0000000e", alu_out); end
    set_r(0, 0, 6'b010000);
    step();
    n_chk++; if (alu_out !== 32'd2) begin n_fail++; $display("FAIL stall_hi: got %h expected 00000002", alu_out); end
  endtask

  task automatic test_reset_mid_div();
    set_r(32'd100, 32'd7, 6'b011010);
    step();
    set_in(1'b0, 0, 0, 0, 0, 3'b000, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    n_chk++; if ({stall, out_valid} !== 2'b00) begin n_fail++; $display("FAIL midrst: stall/valid got %b%b expected 00", stall, out_valid); end
    set_in(1'b1, 32'd3, 32'd4, 0, 5'd8, 3'b000, 6'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    n_chk++; if ({out_valid, alu_out} !== {1'b1, 32'd7}) begin n_fail++; $display("FAIL midrst_add: got %b %h expected 1 00000007", out_valid, alu_out); end
    set_r(0, 0, 6'b010000);
    step();
    n_chk++; if (alu_out !== 32'h0) begin n_fail++; $display("FAIL midrst_hi: got %h expected 00000000", alu_out); end
    set_r(0, 0, 6'b010010);
    step();
    n_chk++; if (alu_out !== 32'h0) begin n_fail++; $display("FAIL midrst_lo: got %h expected 00000000", alu_out); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: stall got %b expected 0", stall); end
  endtask

  task automatic test_lui_bubble();
    set_in(1'b1, 32'd0, 32'hCAFEF00D, 32'h00001234, 5'h11, 3'b111, 6'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    n_chk++; if (alu_out !== 32'h12340000) begin n_fail++; $display("FAIL lui: got %h expected 12340000", alu_out); end
    n_chk++; if ({out_AW, out_regwrite, out_memtoreg, out_memwrite} !== {5'h11, 3'b101}) begin
      n_fail++; $display("FAIL lui_ctrl: got %h %b%b%b expected 11 101", out_AW, out_regwrite, out_memtoreg, out_memwrite);
    end
    n_chk++; if (st_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lui_st: got %h expected cafef00d", st_data); end
    set_in(1'b0, 32'd1, 32'd2, 32'd3, 5'h11, 3'b000, 6'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    n_chk++; if ({out_valid, out_regwrite, out_memwrite} !== 3'b000) begin
      n_fail++; $display("FAIL bubble: valid/rw/mw got %b%b%b expected 000", out_valid, out_regwrite, out_memwrite);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_mult();
    test_div();
    test_stall_inputs();
    test_reset_mid_div();
    test_lui_bubble();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
